ula_operand_sequencer: RTL

Sequential front/back end for the ULA's 5-bit add/subtract datapath. Captures operand A (5 bits) and operand B (4 bits) from a shared 5-bit input bus, launches one add or subtract operation on the combinational adder/subtractor, and holds the adder inputs stable for a programmable settle window. It then registers the sum and flags and signals completion with a one-cycle pulse. A chain mode feeds the previous result back as operand A for accumulate/decrement sequences.

---
 rtl/ula_operand_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/ula_operand_sequencer.sv
// Operand capture and launch sequencer for the ULA 5-bit add/subtract datapath.
// Holds adder inputs for SETTLE_CYCLES, then registers sum/flags and pulses done.
module ula_operand_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] din,
  input  logic       load_a,
  input  logic       load_b,
  input  logic       op_sub,
  input  logic       chain,
  input  logic       start,
  output logic [4:0] add_a,
  output logic [3:0] add_b,
  output logic       add_modo_sub,
  output logic       add_cin,
  input  logic [4:0] add_s,
  input  logic       add_cout,
  input  logic       add_ov,
  output logic [4:0] result,
  output logic       carry,
  output logic       overflow,
  output logic       zero,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, APPLY} state_t;

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic [4:0] a_reg;
  logic [3:0] b_reg;
  logic       launch, capture;

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: if (start) begin
        launch   = 1'b1;
        state_nx = APPLY;
      end
      APPLY: if (cnt == 4'(SETTLE_CYCLES - 1)) begin
        capture  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == APPLY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      add_a        <= '0;
      add_b        <= '0;
      add_modo_sub <= 1'b0;
      add_cin      <= 1'b0;
      result       <= '0;
      carry        <= 1'b0;
      overflow     <= 1'b0;
      zero         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= capture;
      if (state == IDLE) begin
        if (load_a) a_reg <= din;
        if (load_b) b_reg <= din[3:0];
      end
      // launch samples a_reg/b_reg before any same-edge load lands
      if (launch) begin
        add_a        <= chain ? result : a_reg;
        add_b        <= b_reg;
        add_modo_sub <= op_sub;
        add_cin      <= op_sub;
        cnt          <= '0;
      end else if (capture) begin
        result   <= add_s;
        carry    <= add_cout;
        overflow <= add_ov;
        zero     <= (add_s == 5'd0);
      end else if (state == APPLY) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule
